rr_mux_arbiter: RTL and testbench

Round-robin arbiter and output register stage that shares one N:1, M-bit data mux among N requesters. Each cycle it picks one pending requester using a rotating priority pointer, steers that requester's data through the mux, and captures it into a valid/ready output register. It sits between N independent producers and a single downstream consumer. It provides fair, back-to-back, one-word-per-cycle access.

---
 rtl/rr_mux_arbiter_pkg.sv | 23 ++
 rtl/rr_mux_arbiter_param_mux.sv | 36 +++
 rtl/rr_mux_arbiter.sv | 123 ++++++++++++
 tb/tb_rr_mux_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/rr_mux_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// rr_mux_arbiter_pkg : shared constants for round-robin arbiters
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package rr_mux_arbiter_pkg;

  localparam int RR_PTR_RST = 0;

  typedef logic [0:0] arb_state_t;

  localparam arb_state_t ST_EMPTY = 1'b0;
  localparam arb_state_t ST_FULL  = 1'b1;

  // Round-robin successor of idx within 0..n-1.
  function automatic int rr_wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_mux_arbiter_param_mux.sv
// ----------------------------------------------------------------------------
// param_mux : N:1 mux of M-bit slices, selects out of range return zero
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module param_mux
  import rr_mux_arbiter_pkg::*;
#(
  parameter int N         = 16,
  parameter int SEL_LINES = 4,
  parameter int M         = 4
) (
  input  logic [N*M-1:0]       in_data,
  input  logic [SEL_LINES-1:0] sel,
  output logic [M-1:0]         out_data
);

  localparam int NP = 1 << SEL_LINES;

  logic [M-1:0] slices [NP];

  // Pad the table to a full power of two so every select code is defined.
  for (genvar i = 0; i < NP; i++) begin : g_slice
    if (i < N) begin : g_live
      assign slices[i] = in_data[i*M +: M];
    end else begin : g_pad
      assign slices[i] = '0;
    end
  end

  assign out_data = slices[sel];

endmodule

`default_nettype wire

// File: rtl/rr_mux_arbiter.sv
// ----------------------------------------------------------------------------
// rr_mux_arbiter : round-robin arbiter sharing one N:1 mux into a valid/ready
//                  output register
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int N         = 16,
  parameter int SEL_LINES = 4,
  parameter int M         = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 arb_en,
  input  logic [N-1:0]         in_req,
  input  logic [N*M-1:0]       in_data,
  output logic [N-1:0]         in_ack,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [M-1:0]         out_data,
  output logic [SEL_LINES-1:0] out_src
);

  localparam int                   NP        = 1 << SEL_LINES;
  localparam logic [SEL_LINES-1:0] C_PTR_RST = SEL_LINES'(RR_PTR_RST);

  arb_state_t           state_q, state_d;
  logic [SEL_LINES-1:0] ptr_q, ptr_d;
  logic [SEL_LINES-1:0] src_q, src_d;
  logic [M-1:0]         data_q, data_d;

  logic [SEL_LINES-1:0] winner;
  logic [M-1:0]         mux_data;
  logic [NP-1:0]        req_pad;
  logic                 found;
  logic                 load;
  logic                 grant;
  logic                 handshake;

  always_comb begin
    req_pad          = '0;
    req_pad[N-1:0]   = in_req;
  end

  // Scan ptr, ptr+1, ... modulo N; ptr is always below N so one subtract wraps.
  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!found && req_pad[idx[SEL_LINES-1:0]]) begin
        found  = 1'b1;
        winner = idx[SEL_LINES-1:0];
      end
    end
  end

  param_mux #(
    .N         (N),
    .SEL_LINES (SEL_LINES),
    .M         (M)
  ) u_mux (
    .in_data  (in_data),
    .sel      (winner),
    .out_data (mux_data)
  );

  assign load      = arb_en & ((state_q == ST_EMPTY) | out_ready);
  assign grant     = load & found;
  assign handshake = (state_q == ST_FULL) & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      ptr_q   <= C_PTR_RST;
      src_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      src_q   <= src_d;
      data_q  <= data_d;
    end
  end

  // A drained word empties the register even while arb_en blocks new grants.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    src_d   = src_q;
    data_d  = data_q;
    if (grant) begin
      state_d = ST_FULL;
      ptr_d   = SEL_LINES'(rr_wrap_inc(int'(winner), N));
      src_d   = winner;
      data_d  = mux_data;
    end else if (handshake) begin
      state_d = ST_EMPTY;
    end
  end

  always_comb begin
    in_ack = '0;
    if (rst_n && grant) begin
      in_ack = N'(1) << winner;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign out_src   = src_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_mux_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rr_mux_arbiter : vector tables, corner sequences and a random run against
//                     a behavioural round-robin model (N=16 and N=5 builds)
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_rr_mux_arbiter;

  localparam int N  = 16;
  localparam int SL = 4;
  localparam int M  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          arb_en, out_ready, out_valid;
  logic [N-1:0]  in_req, in_ack;
  logic [N*M-1:0] in_data;
  logic [M-1:0]  out_data;
  logic [SL-1:0] out_src;

  logic          en5, ready5, valid5;
  logic [4:0]    req5, ack5;
  logic [19:0]   data5;
  logic [3:0]    odata5;
  logic [2:0]    src5;

  always #5 clk = ~clk;

  rr_mux_arbiter #(.N(N), .SEL_LINES(SL), .M(M)) dut16 (
    .clk(clk), .rst_n(rst_n), .arb_en(arb_en), .in_req(in_req),
    .in_data(in_data), .in_ack(in_ack), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_src(out_src)
  );

  rr_mux_arbiter #(.N(5), .SEL_LINES(3), .M(4)) dut5 (
    .clk(clk), .rst_n(rst_n), .arb_en(en5), .in_req(req5),
    .in_data(data5), .in_ack(ack5), .out_valid(valid5),
    .out_ready(ready5), .out_data(odata5), .out_src(src5)
  );

  int vectors    = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pointer as an integer, winner by modular scan.
  int         m_ptr;
  bit         m_valid;
  logic [3:0] m_data, m_src;

  function automatic int ref_winner(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_cycle(input string tag);
    int         w;
    bit         ld;
    logic [N-1:0] ea;
    @(negedge clk);
    ld = arb_en && (!m_valid || out_ready);
    w  = ref_winner(in_req, m_ptr);
    ea = (ld && w >= 0) ? N'(1 << w) : '0;
    chk({tag, " ack"}, 32'(in_ack), 32'(ea));
    chk({tag, " valid"}, 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      chk({tag, " data"}, 32'(out_data), 32'(m_data));
      chk({tag, " src"}, 32'(out_src), 32'(m_src));
    end
    @(posedge clk);
    if (ld && w >= 0) begin
      m_valid = 1'b1;
      m_data  = in_data[w*M +: M];
      m_src   = 4'(w);
      m_ptr   = (w + 1) % N;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    m_valid = 1'b0;
    m_data  = '0;
    m_src   = '0;
    m_ptr   = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic         en;
    logic         rdy;
    logic [N-1:0] ack;
    logic         valid;
    logic [3:0]   src;
  } vec_t;

  vec_t tbl [18];

  initial begin
    // Requesters 3/9 alternate, then a 4-cycle stall on 5, then arb_en gap.
    tbl[0]  = '{16'h0208, 1'b1, 1'b1, 16'h0008, 1'b0, 4'd0};
    tbl[1]  = '{16'h0208, 1'b1, 1'b1, 16'h0200, 1'b1, 4'd3};
    tbl[2]  = '{16'h0208, 1'b1, 1'b1, 16'h0008, 1'b1, 4'd9};
    tbl[3]  = '{16'h0208, 1'b1, 1'b1, 16'h0200, 1'b1, 4'd3};
    tbl[4]  = '{16'h0020, 1'b1, 1'b1, 16'h0020, 1'b1, 4'd9};
    tbl[5]  = '{16'h0020, 1'b1, 1'b0, 16'h0000, 1'b1, 4'd5};
    tbl[6]  = '{16'h0020, 1'b1, 1'b0, 16'h0000, 1'b1, 4'd5};
    tbl[7]  = '{16'h0020, 1'b1, 1'b0, 16'h0000, 1'b1, 4'd5};
    tbl[8]  = '{16'h0020, 1'b1, 1'b0, 16'h0000, 1'b1, 4'd5};
    tbl[9]  = '{16'h0020, 1'b1, 1'b1, 16'h0020, 1'b1, 4'd5};
    tbl[10] = '{16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 4'd5};
    tbl[11] = '{16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0, 4'd0};
    tbl[12] = '{16'hFFFF, 1'b1, 1'b1, 16'h0040, 1'b0, 4'd0};
    tbl[13] = '{16'hFFFF, 1'b0, 1'b1, 16'h0000, 1'b1, 4'd6};
    tbl[14] = '{16'hFFFF, 1'b0, 1'b1, 16'h0000, 1'b0, 4'd0};
    tbl[15] = '{16'hFFFF, 1'b0, 1'b1, 16'h0000, 1'b0, 4'd0};
    tbl[16] = '{16'hFFFF, 1'b1, 1'b1, 16'h0080, 1'b0, 4'd0};
    tbl[17] = '{16'hFFFF, 1'b1, 1'b1, 16'h0100, 1'b1, 4'd7};

    for (int i = 0; i < N; i++) in_data[i*M +: M] = 4'(i);
    data5     = {4'd7, 4'd6, 4'd5, 4'd4, 4'd3};
    en5       = 1'b1;
    ready5    = 1'b1;
    req5      = '1;
    arb_en    = 1'b1;
    out_ready = 1'b1;
    in_req    = '1;
    rst_n     = 1'b0;

    // Reset holds everything quiet despite full request load.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst ack", 32'(in_ack), 32'h0);
    chk("rst valid", 32'(out_valid), 32'h0);
    chk("rst data", 32'(out_data), 32'h0);
    chk("rst src", 32'(out_src), 32'h0);
    chk("rst ack5", 32'(ack5), 32'h0);
    chk("rst valid5", 32'(valid5), 32'h0);

    // Release mid-traffic: full rotation from pointer 0 on both builds.
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      if (c == 0) begin
        chk("rot first ack", 32'(in_ack), 32'h1);
        chk("rot first valid", 32'(out_valid), 32'h0);
        chk("n5 first ack", 32'(ack5), 32'h1);
      end else begin
        chk("rot valid", 32'(out_valid), 32'h1);
        chk("rot src", 32'(out_src), 32'((c - 1) % 16));
        chk("rot data", 32'(out_data), 32'((c - 1) % 16));
        chk("n5 src", 32'(src5), 32'((c - 1) % 5));
        chk("n5 data", 32'(odata5), 32'((c - 1) % 5 + 3));
      end
      @(posedge clk);
      #1;
    end

    // Table vectors.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      in_req    = tbl[i].req;
      arb_en    = tbl[i].en;
      out_ready = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("tbl%0d ack", i), 32'(in_ack), 32'(tbl[i].ack));
      chk($sformatf("tbl%0d valid", i), 32'(out_valid), 32'(tbl[i].valid));
      if (tbl[i].valid) begin
        chk($sformatf("tbl%0d src", i), 32'(out_src), 32'(tbl[i].src));
        chk($sformatf("tbl%0d data", i), 32'(out_data), 32'(tbl[i].src));
      end
      @(posedge clk);
      #1;
    end

    // Asynchronous reset while FULL and stalled, then restart from pointer 0.
    do_reset();
    in_req    = 16'h0020;
    arb_en    = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("stall full valid", 32'(out_valid), 32'h1);
    chk("stall full src", 32'(out_src), 32'h5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async valid", 32'(out_valid), 32'h0);
    chk("async ack", 32'(in_ack), 32'h0);
    chk("async src", 32'(out_src), 32'h0);
    in_req    = '1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-rst ack", 32'(in_ack), 32'h1);
    @(posedge clk);
    #1;

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      in_req    = (i % 3 == 0) ? N'($urandom) : N'($urandom & $urandom & $urandom);
      in_data   = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      arb_en    = ($urandom_range(0, 7) != 0);
      model_cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
